mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares the single memory bus (bram/peripheral side) between two masters: m0 = cpu core, m1 = DMA/video.
//  Both sides use the 4-phase req/ready handshake the cpu core drives: req level + we/addr/data, ready level back.
//  Round-robin or fixed-priority grant, one transaction at a time, with a timeout so a dead slave cannot hang a master.
// PARAMETERS
//  AW            32            address width
//  DW            32            data width
//  FIXED_PRIO    0             0 = round-robin; 1 = m0 always wins simultaneous requests
//  TIMEOUT       255           cycles in BUSY before forced completion; 0 = timeout disabled
//  TIMEOUT_DATA  32'hDEADBEEF  read data returned on timeout
// PORTS
//  i_clk         in   1   clock
//  i_rst         in   1   reset, asynchronous, active-high
//  i_mN_req      in   1   master N request level (N = 0,1); held until o_mN_ready seen
//  i_mN_we       in   1   master N write enable (1 = write)
//  i_mN_addr     in   AW  master N address
//  i_mN_data     in   DW  master N write data
//  o_mN_data     out  DW  master N read data, valid while o_mN_ready = 1
//  o_mN_ready    out  1   master N transaction complete (level)
//  o_mN_err      out  1   master N transaction ended by timeout (qualifies o_mN_ready)
//  o_mem_req     out  1   request to memory
//  o_mem_we      out  1   write enable to memory
//  o_mem_addr    out  AW  address to memory
//  o_mem_data    out  DW  write data to memory
//  i_mem_data    in   DW  read data from memory
//  i_mem_ready   in   1   memory completion (level, 4-phase)
//  o_grant       out  2   one-hot current owner; 0 when idle
// BEHAVIOUR
//  Reset (async): state IDLE; all outputs 0; last_grant = m1 (so m0 wins first tie); timeout counter 0.
//  All outputs registered. States: IDLE -> BUSY -> DONE -> IDLE.
//  IDLE: on posedge with any i_mN_req = 1, choose winner, latch its we/addr/data onto o_mem_*,
//   set o_mem_req = 1, o_grant, clear counter -> BUSY. o_mem_req is visible 1 cycle after req first sampled.
//  Arbitration: single requester wins. Both requesting: FIXED_PRIO=1 -> m0; else the master not in last_grant.
//  BUSY: o_mem_* held stable. Counter increments every cycle.
//   i_mem_ready = 1: o_mem_req <= 0; o_mN_ready <= 1; if read, o_mN_data <= i_mem_data
//    (writes leave o_mN_data unchanged) -> DONE.
//   counter == TIMEOUT-1 with no ready (TIMEOUT != 0): o_mem_req <= 0; o_mN_ready <= 1; o_mN_err <= 1;
//    read -> o_mN_data <= TIMEOUT_DATA -> DONE. Ready and timeout on the same edge: ready wins, err = 0.
//  DONE: holds o_mN_ready/o_mN_err until granted i_mN_req = 0 AND i_mem_ready = 0 are both sampled; then clears
//   them, o_grant <= 0, last_grant <= owner -> IDLE. New arbitration earliest the next posedge (min 1 idle cycle).
//  Non-owner: o_mN_ready/err stay 0; its held request is served next (no starvation in round-robin mode).
//  Owner drops req during BUSY (protocol violation): memory access still completes; DONE then exits at once
//   once i_mem_ready = 0. Write already issued is never cancelled.
//  Requests changing we/addr/data after grant are ignored (latched values used).
//  Reset mid-transaction: o_mem_req and o_mN_ready drop asynchronously; no completion reported.
// TESTING
//  m0 read 0x1234, mem ready after 3 cycles with 0xA5 -> o_mem_req 1 cycle after req, o_m0_data=0xA5, err=0.
//  m0 and m1 request same cycle, round-robin, two cycles each -> grants m0,m1,m0,m1; idle cycle between.
//  FIXED_PRIO=1, both hold req continuously -> m0 granted every transaction, m1 never while m0 requests.
//  TIMEOUT=8, mem never ready, m1 read -> o_m1_ready+o_m1_err at 8th BUSY cycle, data 0xDEADBEEF.
//  m0 write 0x55 to 0x0200 while m1 requests -> o_mem_we=1, addr/data stable through BUSY, o_m0_data unchanged.
//  Assert i_rst during BUSY -> all outputs 0 immediately; after release m0 wins first tie.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the shared memory bus: one 4-phase req/ready transaction at a time,
// round-robin or fixed priority, with a BUSY timeout so a dead slave cannot hang a master.
module mem_bus_arbiter #(
    parameter int            AW           = 32,
    parameter int            DW           = 32,
    parameter int            FIXED_PRIO   = 0,
    parameter int            TIMEOUT      = 255,
    parameter logic [DW-1:0] TIMEOUT_DATA = DW'(32'hDEADBEEF)
) (
    input  logic          i_clk,
    input  logic          i_rst,

    input  logic          i_m0_req,
    input  logic          i_m0_we,
    input  logic [AW-1:0] i_m0_addr,
    input  logic [DW-1:0] i_m0_data,
    output logic [DW-1:0] o_m0_data,
    output logic          o_m0_ready,
    output logic          o_m0_err,

    input  logic          i_m1_req,
    input  logic          i_m1_we,
    input  logic [AW-1:0] i_m1_addr,
    input  logic [DW-1:0] i_m1_data,
    output logic [DW-1:0] o_m1_data,
    output logic          o_m1_ready,
    output logic          o_m1_err,

    output logic          o_mem_req,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_data,
    input  logic [DW-1:0] i_mem_data,
    input  logic          i_mem_ready,

    output logic [1:0]    o_grant
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t      state;
    logic        owner;
    logic        last_grant;
    logic [31:0] count;

    logic        pick_m1;
    logic        owner_req;
    logic        timed_out;
    logic [DW-1:0] done_data;

    // On a tie, round-robin hands the bus to whichever master did not own it last.
    always_comb begin
        pick_m1 = i_m1_req;
        if (i_m0_req && i_m1_req) begin
            pick_m1 = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant;
        end
    end

    assign owner_req = owner ? i_m1_req : i_m0_req;
    assign timed_out = (TIMEOUT != 0) && (count == 32'(TIMEOUT - 1));
    assign done_data = i_mem_ready ? i_mem_data : TIMEOUT_DATA;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            count      <= '0;
            o_m0_data  <= '0;
            o_m0_ready <= 1'b0;
            o_m0_err   <= 1'b0;
            o_m1_data  <= '0;
            o_m1_ready <= 1'b0;
            o_m1_err   <= 1'b0;
            o_mem_req  <= 1'b0;
            o_mem_we   <= 1'b0;
            o_mem_addr <= '0;
            o_mem_data <= '0;
            o_grant    <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (i_m0_req || i_m1_req) begin
                        owner      <= pick_m1;
                        o_grant    <= pick_m1 ? 2'b10 : 2'b01;
                        o_mem_we   <= pick_m1 ? i_m1_we   : i_m0_we;
                        o_mem_addr <= pick_m1 ? i_m1_addr : i_m0_addr;
                        o_mem_data <= pick_m1 ? i_m1_data : i_m0_data;
                        o_mem_req  <= 1'b1;
                        count      <= '0;
                        state      <= BUSY;
                    end
                end

                // A real ready always beats a timeout landing on the same edge.
                BUSY: begin
                    if (i_mem_ready || timed_out) begin
                        o_mem_req <= 1'b0;
                        if (owner) begin
                            o_m1_ready <= 1'b1;
                            o_m1_err   <= ~i_mem_ready;
                            if (!o_mem_we) begin
                                o_m1_data <= done_data;
                            end
                        end else begin
                            o_m0_ready <= 1'b1;
                            o_m0_err   <= ~i_mem_ready;
                            if (!o_mem_we) begin
                                o_m0_data <= done_data;
                            end
                        end
                        state <= DONE;
                    end else begin
                        count <= count + 32'd1;
                    end
                end

                DONE: begin
                    if (!owner_req && !i_mem_ready) begin
                        o_m0_ready <= 1'b0;
                        o_m0_err   <= 1'b0;
                        o_m1_ready <= 1'b0;
                        o_m1_err   <= 1'b0;
                        o_grant    <= 2'b00;
                        last_grant <= owner;
                        state      <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: a round-robin/TIMEOUT=8 instance and a fixed-priority/no-timeout
// instance, each driven by random masters and a random slave and checked against a transaction model.
module tb_mem_bus_arbiter;

    localparam int          AW      = 32;
    localparam int          DW      = 32;
    localparam logic [31:0] TO_DATA = 32'hDEADBEEF;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    logic        m_req   [2][2];
    logic        m_we    [2][2];
    logic [31:0] m_addr  [2][2];
    logic [31:0] m_wdata [2][2];
    logic        mem_ready [2];
    logic [31:0] mem_rdata [2];

    logic [31:0] dut_rdata [2][2];
    logic        dut_ready [2][2];
    logic        dut_err   [2][2];
    logic        dut_mem_req  [2];
    logic        dut_mem_we   [2];
    logic [31:0] dut_mem_addr [2];
    logic [31:0] dut_mem_data [2];
    logic [1:0]  dut_grant    [2];

    generate
        for (genvar g = 0; g < 2; g++) begin : g_dut
            mem_bus_arbiter #(
                .AW(AW), .DW(DW), .FIXED_PRIO(g), .TIMEOUT((g == 0) ? 8 : 0), .TIMEOUT_DATA(TO_DATA)
            ) u_dut (
                .i_clk(clk), .i_rst(rst),
                .i_m0_req(m_req[g][0]), .i_m0_we(m_we[g][0]), .i_m0_addr(m_addr[g][0]), .i_m0_data(m_wdata[g][0]),
                .o_m0_data(dut_rdata[g][0]), .o_m0_ready(dut_ready[g][0]), .o_m0_err(dut_err[g][0]),
                .i_m1_req(m_req[g][1]), .i_m1_we(m_we[g][1]), .i_m1_addr(m_addr[g][1]), .i_m1_data(m_wdata[g][1]),
                .o_m1_data(dut_rdata[g][1]), .o_m1_ready(dut_ready[g][1]), .o_m1_err(dut_err[g][1]),
                .o_mem_req(dut_mem_req[g]), .o_mem_we(dut_mem_we[g]), .o_mem_addr(dut_mem_addr[g]),
                .o_mem_data(dut_mem_data[g]), .i_mem_data(mem_rdata[g]), .i_mem_ready(mem_ready[g]),
                .o_grant(dut_grant[g])
            );
        end
    endgenerate

    // Transaction-level model: who owns the bus, whether the access has finished, and how.
    int          fixed_prio [2] = '{0, 1};
    int          timeout    [2] = '{8, 0};
    int          owner      [2];
    int          age        [2];
    int          last_own   [2];
    bit          fin        [2];
    bit          terr       [2];
    logic        t_we       [2];
    logic [31:0] t_addr     [2];
    logic [31:0] t_data     [2];
    logic [31:0] exp_rdata  [2][2];

    int slave_wait [2];
    bit auto_m [2];
    bit auto_s [2];
    bit always_req;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            owner[d] = -1; age[d] = 0; last_own[d] = 1; fin[d] = 0; terr[d] = 0;
            t_we[d] = 1'b0; t_addr[d] = '0; t_data[d] = '0;
            exp_rdata[d][0] = '0; exp_rdata[d][1] = '0;
        end
    endtask

    function automatic bit exp_mem_req(input int d);
        return owner[d] >= 0 && !fin[d];
    endfunction

    function automatic bit exp_ready(input int d, input int n);
        return owner[d] == n && fin[d];
    endfunction

    // Advance the model by one clock edge using the inputs the DUT is about to sample.
    task automatic model_step();
        int w;
        for (int d = 0; d < 2; d++) begin
            if (owner[d] < 0) begin
                if (m_req[d][0] || m_req[d][1]) begin
                    if (m_req[d][0] && m_req[d][1]) w = (fixed_prio[d] != 0) ? 0 : 1 - last_own[d];
                    else w = m_req[d][1] ? 1 : 0;
                    owner[d] = w; age[d] = 0; fin[d] = 0; terr[d] = 0;
                    t_we[d] = m_we[d][w]; t_addr[d] = m_addr[d][w]; t_data[d] = m_wdata[d][w];
                end
            end else if (!fin[d]) begin
                if (mem_ready[d]) begin
                    fin[d] = 1;
                    if (!t_we[d]) exp_rdata[d][owner[d]] = mem_rdata[d];
                end else if (timeout[d] != 0 && age[d] == timeout[d] - 1) begin
                    fin[d] = 1; terr[d] = 1;
                    if (!t_we[d]) exp_rdata[d][owner[d]] = TO_DATA;
                end else begin
                    age[d]++;
                end
            end else if (!m_req[d][owner[d]] && !mem_ready[d]) begin
                last_own[d] = owner[d];
                owner[d] = -1;
            end
        end
    endtask

    task automatic checkOutput();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("dut%0d mem_req", d), 32'(dut_mem_req[d]), 32'(exp_mem_req(d)));
            chk($sformatf("dut%0d grant", d), 32'(dut_grant[d]),
                (owner[d] < 0) ? 32'd0 : ((owner[d] == 0) ? 32'd1 : 32'd2));
            chk($sformatf("dut%0d mem_we", d), 32'(dut_mem_we[d]), 32'(t_we[d]));
            chk($sformatf("dut%0d mem_addr", d), dut_mem_addr[d], t_addr[d]);
            chk($sformatf("dut%0d mem_data", d), dut_mem_data[d], t_data[d]);
            for (int n = 0; n < 2; n++) begin
                chk($sformatf("dut%0d m%0d ready", d, n), 32'(dut_ready[d][n]), 32'(exp_ready(d, n)));
                chk($sformatf("dut%0d m%0d err", d, n), 32'(dut_err[d][n]), 32'(exp_ready(d, n) && terr[d]));
                chk($sformatf("dut%0d m%0d rdata", d, n), dut_rdata[d][n], exp_rdata[d][n]);
            end
        end
    endtask

    // Random masters honour the 4-phase protocol (rarely violating it); the slave answers with random latency.
    task automatic applyStimulus();
        int r;
        for (int d = 0; d < 2; d++) begin
            if (auto_m[d]) begin
                for (int n = 0; n < 2; n++) begin
                    if (m_req[d][n]) begin
                        if (exp_ready(d, n)) begin
                            m_req[d][n] = 1'b0;
                        end else if (!always_req && owner[d] == n && !fin[d] && $urandom_range(99) < 3) begin
                            m_req[d][n] = 1'b0;
                        end else if (owner[d] == n && $urandom_range(99) < 30) begin
                            m_we[d][n] = 1'($urandom_range(1));
                            m_addr[d][n] = $urandom;
                            m_wdata[d][n] = $urandom;
                        end
                    end else if (!exp_ready(d, n) && owner[d] != n && (always_req || $urandom_range(99) < 30)) begin
                        m_req[d][n] = 1'b1;
                        m_we[d][n] = 1'($urandom_range(1));
                        m_addr[d][n] = $urandom;
                        m_wdata[d][n] = $urandom;
                    end
                end
            end
            if (auto_s[d]) begin
                if (mem_ready[d]) begin
                    if (!exp_mem_req(d) && $urandom_range(99) < 60) mem_ready[d] = 1'b0;
                    slave_wait[d] = -1;
                end else if (exp_mem_req(d)) begin
                    if (slave_wait[d] < 0) begin
                        r = $urandom_range(99);
                        if (always_req) slave_wait[d] = $urandom_range(3);
                        else if (d == 0 && r < 15) slave_wait[d] = 1000;
                        else if (r < 25) slave_wait[d] = 7;
                        else slave_wait[d] = $urandom_range(3);
                    end
                    if (slave_wait[d] == 0) begin
                        mem_ready[d] = 1'b1;
                        mem_rdata[d] = $urandom;
                    end else begin
                        slave_wait[d]--;
                    end
                end else begin
                    slave_wait[d] = -1;
                end
            end
        end
    endtask

    task automatic cycle();
        applyStimulus();
        model_step();
        @(posedge clk);
        @(negedge clk);
        checkOutput();
    endtask

    task automatic clear_inputs();
        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 2; n++) begin
                m_req[d][n] = 1'b0; m_we[d][n] = 1'b0; m_addr[d][n] = '0; m_wdata[d][n] = '0;
            end
            mem_ready[d] = 1'b0; mem_rdata[d] = '0; slave_wait[d] = -1;
        end
    endtask

    initial begin
        int last0, alt_bad, grants0, fp_m0, fp_m1_after;
        bit seen_m0, found;
        logic [1:0] prev_g [2];

        rst = 1'b1;
        clear_inputs();
        model_reset();
        auto_m = '{0, 1};
        auto_s = '{0, 1};
        always_req = 0;

        @(negedge clk);
        checkOutput();
        chk("reset grant", 32'(dut_grant[0]), 32'd0);
        chk("reset mem_req", 32'(dut_mem_req[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // m0 read of 0x1234, memory answers 0xA5 after three BUSY cycles.
        m_req[0][0] = 1'b1; m_we[0][0] = 1'b0; m_addr[0][0] = 32'h1234;
        cycle();
        chk("read req visible", 32'(dut_mem_req[0]), 32'd1);
        chk("read grant", 32'(dut_grant[0]), 32'd1);
        chk("read addr", dut_mem_addr[0], 32'h1234);
        cycle();
        cycle();
        mem_ready[0] = 1'b1; mem_rdata[0] = 32'hA5;
        cycle();
        chk("read ready", 32'(dut_ready[0][0]), 32'd1);
        chk("read data", dut_rdata[0][0], 32'hA5);
        chk("read err", 32'(dut_err[0][0]), 32'd0);
        chk("read req dropped", 32'(dut_mem_req[0]), 32'd0);
        m_req[0][0] = 1'b0; mem_ready[0] = 1'b0;
        cycle();
        chk("read ready cleared", 32'(dut_ready[0][0]), 32'd0);
        chk("read grant cleared", 32'(dut_grant[0]), 32'd0);

        // m0 write 0x55 to 0x0200 while m1 queues up a read; m0 changes its inputs after grant.
        m_req[0][0] = 1'b1; m_we[0][0] = 1'b1; m_addr[0][0] = 32'h0200; m_wdata[0][0] = 32'h55;
        cycle();
        chk("write grant", 32'(dut_grant[0]), 32'd1);
        m_req[0][1] = 1'b1; m_we[0][1] = 1'b0; m_addr[0][1] = 32'h0300;
        m_addr[0][0] = 32'hFFFF; m_wdata[0][0] = 32'h99;
        cycle();
        chk("write we", 32'(dut_mem_we[0]), 32'd1);
        chk("write addr held", dut_mem_addr[0], 32'h0200);
        chk("write data held", dut_mem_data[0], 32'h55);
        mem_ready[0] = 1'b1; mem_rdata[0] = 32'h77;
        cycle();
        chk("write ready", 32'(dut_ready[0][0]), 32'd1);
        chk("write leaves rdata", dut_rdata[0][0], 32'hA5);
        m_req[0][0] = 1'b0; mem_ready[0] = 1'b0;
        cycle();
        chk("idle between grants", 32'(dut_grant[0]), 32'd0);

        // m1's queued read now meets a dead slave and must time out on the 8th BUSY cycle.
        cycle();
        chk("m1 grant", 32'(dut_grant[0]), 32'd2);
        chk("m1 addr", dut_mem_addr[0], 32'h0300);
        for (int i = 1; i <= 7; i++) cycle();
        chk("no early timeout", 32'(dut_ready[0][1]), 32'd0);
        cycle();
        chk("timeout ready", 32'(dut_ready[0][1]), 32'd1);
        chk("timeout err", 32'(dut_err[0][1]), 32'd1);
        chk("timeout data", dut_rdata[0][1], TO_DATA);
        m_req[0][1] = 1'b0;
        cycle();
        chk("timeout cleared", 32'(dut_err[0][1]), 32'd0);

        auto_m[0] = 1; auto_s[0] = 1; slave_wait[0] = -1;
        repeat (1500) cycle();

        // Both masters requesting back to back: alternation vs. m0 always winning.
        always_req = 1;
        repeat (30) cycle();
        last0 = 0; alt_bad = 0; grants0 = 0; fp_m0 = 0; fp_m1_after = 0; seen_m0 = 0;
        prev_g[0] = dut_grant[0]; prev_g[1] = dut_grant[1];
        repeat (200) begin
            cycle();
            if (dut_grant[0] != 2'b00 && prev_g[0] == 2'b00) begin
                if (last0 != 0 && int'(dut_grant[0]) == last0) alt_bad++;
                last0 = int'(dut_grant[0]);
                grants0++;
            end
            if (dut_grant[1] != 2'b00 && prev_g[1] == 2'b00) begin
                if (dut_grant[1] == 2'b01) begin
                    seen_m0 = 1; fp_m0++;
                end else if (seen_m0) begin
                    fp_m1_after++;
                end
            end
            prev_g[0] = dut_grant[0]; prev_g[1] = dut_grant[1];
        end
        chk("rr alternation breaks", 32'(alt_bad), 32'd0);
        chk("rr enough grants", 32'(grants0 >= 10), 32'd1);
        chk("fp m1 grants while m0 waits", 32'(fp_m1_after), 32'd0);
        chk("fp enough m0 grants", 32'(fp_m0 >= 10), 32'd1);
        always_req = 0;

        // Reset in the middle of a dut0 access.
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            cycle();
            if (exp_mem_req(0)) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL busy wait: got none in 200 cycles, expected a BUSY dut0");
        end else begin
            #2 rst = 1'b1;
            #1;
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("dut%0d async mem_req", d), 32'(dut_mem_req[d]), 32'd0);
                chk($sformatf("dut%0d async grant", d), 32'(dut_grant[d]), 32'd0);
                chk($sformatf("dut%0d async mem_addr", d), dut_mem_addr[d], 32'd0);
                for (int n = 0; n < 2; n++) begin
                    chk($sformatf("dut%0d async m%0d ready", d, n), 32'(dut_ready[d][n]), 32'd0);
                    chk($sformatf("dut%0d async m%0d rdata", d, n), dut_rdata[d][n], 32'd0);
                end
            end
            model_reset();
            clear_inputs();
            auto_m = '{0, 0};
            @(negedge clk);
            checkOutput();
            rst = 1'b0;
            for (int d = 0; d < 2; d++) begin
                m_req[d][0] = 1'b1; m_req[d][1] = 1'b1;
            end
            cycle();
            chk("dut0 tie after reset", 32'(dut_grant[0]), 32'd1);
            chk("dut1 tie after reset", 32'(dut_grant[1]), 32'd1);
            auto_m = '{1, 1};
            repeat (50) cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
